// File: rtl/stream_arb_pkg.sv
`default_nettype none
// =============================================================================
// Module   : stream_arb_pkg
// Purpose  : Shared widths and FSM encodings for the 4-channel byte arbiter.
// Revision : 1.0
// =============================================================================
package stream_arb_pkg;

    localparam int N_CH   = 4;
    localparam int DATA_W = 8;
    localparam int CH_W   = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

endpackage : stream_arb_pkg
`default_nettype wire

// File: rtl/stream_arb_rr_pick.sv
`default_nettype none
// =============================================================================
// Module   : rr_pick
// Purpose  : Round-robin search: first request at or after (last+1), wrapping.
// Revision : 1.0
// =============================================================================
module rr_pick
    import stream_arb_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] last,
    output logic [CH_W-1:0] idx,
    output logic            any
);

    // Walk from farthest to nearest so the nearest hit after 'last' wins.
    always_comb begin
        idx = '0;
        for (int i = N_CH; i >= 1; i--) begin
            if (req[last + CH_W'(i)]) begin
                idx = last + CH_W'(i);
            end
        end
        any = |req;
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/stream_arb.sv
`default_nettype none
// =============================================================================
// Module   : stream_arb
// Purpose  : Round-robin byte-stream arbiter, bounded bursts, 1-deep output reg.
// Revision : 1.0
// =============================================================================
module stream_arb
    import stream_arb_pkg::*;
#(
    parameter int MAX_BURST = 16
)
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N_CH*DATA_W-1:0]   i_data,
    input  logic [N_CH-1:0]          i_valid,
    output logic [N_CH-1:0]          o_ready,
    input  logic [N_CH-1:0]          i_mask,
    output logic [DATA_W-1:0]        o_data,
    output logic [CH_W-1:0]          o_chan,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [0:0]        r_state;
    logic [CH_W-1:0]   r_grant;
    logic [CH_W-1:0]   r_last_grant;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_data;
    logic [CH_W-1:0]   r_chan;
    logic              r_valid;

    logic [N_CH-1:0]   w_cand;
    logic [CH_W-1:0]   w_pick;
    logic              w_pick_any;
    logic              w_in_grant;
    logic              w_up_ok;
    logic              w_up_xfer;
    logic              w_dn_xfer;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_burst_done;
    logic [DATA_W-1:0] w_gbyte;

    assign w_cand = i_valid & i_mask;

    rr_pick u_pick (
        .req  (w_cand),
        .last (r_last_grant),
        .idx  (w_pick),
        .any  (w_pick_any)
    );

    assign w_in_grant   = (r_state == ST_GRANT);
    assign w_up_ok      = w_in_grant && i_mask[r_grant] && (!r_valid || i_ready);
    assign w_up_xfer    = w_up_ok && i_valid[r_grant];
    assign w_dn_xfer    = r_valid && i_ready;
    assign w_cnt_next   = r_cnt + CNT_W'(1);
    assign w_burst_done = w_up_xfer && (w_cnt_next == CNT_W'(MAX_BURST));
    assign w_gbyte      = i_data[{r_grant, 3'b000} +: DATA_W];

    always_comb begin
        o_ready          = '0;
        o_ready[r_grant] = w_up_ok;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= CH_W'(N_CH - 1);
            r_cnt        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_cnt        <= '0;
                        r_state      <= ST_GRANT;
                    end
                end
                default: begin
                    if (w_up_xfer) begin
                        r_cnt <= w_cnt_next;
                    end
                    // Any of these ends the burst; the bubble in IDLE re-arbitrates.
                    if (w_burst_done || !i_valid[r_grant] || !i_mask[r_grant]) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Output register drains on its own, independent of the arbitration FSM.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data  <= '0;
            r_chan  <= '0;
            r_valid <= 1'b0;
        end else if (w_up_xfer) begin
            r_data  <= w_gbyte;
            r_chan  <= r_grant;
            r_valid <= 1'b1;
        end else if (w_dn_xfer) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_chan  = r_chan;
    assign o_valid = r_valid;
    assign o_busy  = w_in_grant;

endmodule : stream_arb
`default_nettype wire

// File: tb/tb_stream_arb.sv
`default_nettype none
// =============================================================================
// Module   : tb_stream_arb
// Purpose  : Two arbiters (MAX_BURST 4 and 16) against a rule-level reference.
// Revision : 1.0
// =============================================================================
module tb_stream_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mask;
    logic        rdy;
    logic [3:0]  in_valid [2];
    logic [31:0] in_data  [2];

    logic [3:0]  ordy0, ordy1;
    logic [7:0]  od0, od1;
    logic [1:0]  oc0, oc1;
    logic        ov0, ov1, ob0, ob1;

    int total = 0;
    int bad   = 0;

    int mb     [2];
    int m_busy [2];
    int m_g    [2];
    int m_last [2];
    int m_cnt  [2];
    int m_ov   [2];
    int m_od   [2];
    int m_oc   [2];

    logic [3:0] rs [2];
    int k [2];
    int obs_chan [2][64];
    int obs_data [2][64];
    int obs_n    [2];

    always #5 clk = ~clk;

    stream_arb #(.MAX_BURST(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_data(in_data[0]), .i_valid(in_valid[0]),
        .o_ready(ordy0), .i_mask(mask), .o_data(od0), .o_chan(oc0),
        .o_valid(ov0), .i_ready(rdy), .o_busy(ob0)
    );

    stream_arb #(.MAX_BURST(16)) u_dut16 (
        .i_clk(clk), .i_rst(rst), .i_data(in_data[1]), .i_valid(in_valid[1]),
        .o_ready(ordy1), .i_mask(mask), .o_data(od1), .o_chan(oc1),
        .o_valid(ov1), .i_ready(rdy), .o_busy(ob1)
    );

    function automatic logic [3:0] g_rdy(int d); return (d == 0) ? ordy0 : ordy1; endfunction
    function automatic logic [7:0] g_od(int d);  return (d == 0) ? od0 : od1;     endfunction
    function automatic logic [1:0] g_oc(int d);  return (d == 0) ? oc0 : oc1;     endfunction
    function automatic logic       g_ov(int d);  return (d == 0) ? ov0 : ov1;     endfunction
    function automatic logic       g_ob(int d);  return (d == 0) ? ob0 : ob1;     endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        m_busy[d] = 0; m_g[d] = 0; m_last[d] = 3; m_cnt[d] = 0;
        m_ov[d] = 0; m_od[d] = 0; m_oc[d] = 0;
    endtask

    function automatic logic [3:0] exp_ready(input int d);
        logic [3:0] r;
        r = 4'b0000;
        if (m_busy[d] != 0 && mask[m_g[d]] && (m_ov[d] == 0 || rdy)) r[m_g[d]] = 1'b1;
        return r;
    endfunction

    // Reference: one clock edge of the arbiter rules, applied to the current inputs.
    task automatic model_step(input int d);
        logic [3:0]  r;
        logic [3:0]  cand;
        logic [31:0] word;
        bit          up, dn, found;
        int          c;
        if (rst) begin
            model_reset(d);
            return;
        end
        r    = exp_ready(d);
        up   = (r[m_g[d]] && in_valid[d][m_g[d]]);
        dn   = (m_ov[d] != 0 && rdy);
        word = in_data[d];
        if (up) begin
            m_od[d] = int'((word >> (8 * m_g[d])) & 32'hFF);
            m_oc[d] = m_g[d];
            m_ov[d] = 1;
        end else if (dn) begin
            m_ov[d] = 0;
        end
        if (m_busy[d] == 0) begin
            cand  = in_valid[d] & mask;
            found = 0;
            for (int i = 1; i <= 4; i++) begin
                c = (m_last[d] + i) % 4;
                if (!found && cand[c]) begin
                    found = 1; m_g[d] = c; m_last[d] = c; m_cnt[d] = 0; m_busy[d] = 1;
                end
            end
        end else begin
            if (up) m_cnt[d]++;
            if ((up && m_cnt[d] == mb[d]) || !in_valid[d][m_g[d]] || !mask[m_g[d]]) m_busy[d] = 0;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk("ready", d, 32'(g_rdy(d)), 32'(exp_ready(d)));
            chk("valid", d, 32'(g_ov(d)),  32'(m_ov[d]));
            chk("data",  d, 32'(g_od(d)),  32'(m_od[d]));
            chk("chan",  d, 32'(g_oc(d)),  32'(m_oc[d]));
            chk("busy",  d, 32'(g_ob(d)),  32'(m_busy[d]));
            if (g_ov(d) && rdy && obs_n[d] < 64) begin
                obs_chan[d][obs_n[d]] = int'(g_oc(d));
                obs_data[d][obs_n[d]] = int'(g_od(d));
                obs_n[d]++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        for (int d = 0; d < 2; d++) rs[d] = g_rdy(d);
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_step(d);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid[0] = 4'b0000;
        in_valid[1] = 4'b0000;
        repeat (n) tick();
        obs_n[0] = 0; obs_n[1] = 0;
        k[0] = 0; k[1] = 0;
    endtask

    task automatic all_valid(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid[0] = 4'b1111; in_valid[1] = 4'b1111;
            in_data[0] = $urandom; in_data[1] = $urandom;
            tick();
        end
    endtask

    // One cycle of a single-channel source that advances on each accepted byte.
    task automatic feed_step(input int ch, input int base, input int n);
        logic [31:0] w;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = (k[d] < n) ? 4'(1 << ch) : 4'b0000;
            w = $urandom;
            w[8*ch +: 8] = 8'(base + k[d]);
            in_data[d] = w;
        end
        tick();
        for (int d = 0; d < 2; d++)
            if (in_valid[d][ch] && rs[d][ch]) k[d]++;
    endtask

    initial begin
        int gc;
        int ng;
        mb[0] = 4; mb[1] = 16;
        rst = 1'b1; mask = 4'b0000; rdy = 1'b0;
        in_valid[0] = '0; in_valid[1] = '0; in_data[0] = '0; in_data[1] = '0;
        obs_n[0] = 0; obs_n[1] = 0; k[0] = 0; k[1] = 0;
        model_reset(0); model_reset(1);

        // Reset state
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", d, 32'(g_ov(d)), 0);
            chk("rst_ready", d, 32'(g_rdy(d)), 0);
            chk("rst_busy",  d, 32'(g_ob(d)), 0);
        end
        rst = 1'b0;

        // All channels valid, burst of 4: grants 0,1,2,3,0
        mask = 4'b1111; rdy = 1'b1;
        all_valid(28);
        chk("rr_count", 0, 32'(obs_n[0] >= 20), 1);
        for (int i = 0; i < 20; i++) chk("rr_order", 0, 32'(obs_chan[0][i]), 32'((i / 4) % 4));

        // Only channel 2, ten bytes 0xA0..0xA9
        idle(4);
        for (int i = 0; i < 20; i++) feed_step(2, 'hA0, 10);
        for (int d = 0; d < 2; d++) begin
            chk("ch2_count", d, 32'(obs_n[d]), 10);
            for (int i = 0; i < 10; i++) begin
                chk("ch2_data", d, 32'(obs_data[d][i]), 32'('hA0 + i));
                chk("ch2_chan", d, 32'(obs_chan[d][i]), 2);
            end
        end

        // Downstream stall holding 0x11
        idle(4);
        rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            feed_step(0, 'h11, 3);
            if (ov0 && ov1) break;
        end
        chk("stall_ov_seen", 0, 32'(ov0), 1);
        chk("stall_ov_seen", 1, 32'(ov1), 1);
        for (int i = 0; i < 5; i++) begin
            feed_step(0, 'h11, 3);
            for (int d = 0; d < 2; d++) begin
                chk("stall_data",  d, 32'(g_od(d)), 'h11);
                chk("stall_ready", d, 32'(g_rdy(d)), 0);
            end
        end
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) feed_step(0, 'h11, 3);
        in_valid[0] = '0; in_valid[1] = '0;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            chk("stall_count", d, 32'(obs_n[d]), 3);
            for (int i = 0; i < 3; i++) chk("stall_seq", d, 32'(obs_data[d][i]), 32'('h11 + i));
        end

        // Mask 1010: only odd channels served
        idle(4);
        mask = 4'b1010;
        all_valid(24);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < obs_n[d]; i++) chk("mask_chan_odd", d, 32'(obs_chan[d][i] % 2), 1);

        // Mask of granted channel dropped after three bytes
        mask = 4'b1111;
        idle(4);
        for (int i = 0; i < 20; i++) begin
            all_valid(1);
            if (m_busy[1] != 0 && m_cnt[1] == 3) break;
        end
        gc = m_g[1];
        mask[gc] = 1'b0;
        all_valid(10);
        ng = 0;
        for (int i = 0; i < obs_n[1]; i++) if (obs_chan[1][i] == gc) ng++;
        chk("maskdrop_bytes", 1, 32'(ng), 3);
        chk("maskdrop_next", 1, 32'(obs_chan[1][3]), 32'((gc + 1) % 4));

        // Asynchronous reset mid-burst
        mask = 4'b1111;
        idle(4);
        all_valid(4);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("arst_valid", d, 32'(g_ov(d)), 0);
            chk("arst_data",  d, 32'(g_od(d)), 0);
            chk("arst_chan",  d, 32'(g_oc(d)), 0);
            chk("arst_busy",  d, 32'(g_ob(d)), 0);
            chk("arst_ready", d, 32'(g_rdy(d)), 0);
            model_reset(d);
        end
        tick(); tick();
        rst = 1'b0;
        obs_n[0] = 0; obs_n[1] = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid[0] = 4'b0110; in_valid[1] = 4'b0110;
            in_data[0] = $urandom; in_data[1] = $urandom;
            tick();
        end
        chk("post_rst_grant", 0, 32'(obs_chan[0][0]), 1);
        chk("post_rst_grant", 1, 32'(obs_chan[1][0]), 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid[0] = 4'($urandom);
            in_valid[1] = in_valid[0];
            mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
            rdy  = ($urandom_range(0, 3) != 0);
            in_data[0] = $urandom;
            in_data[1] = in_data[0];
            tick();
            obs_n[0] = 0; obs_n[1] = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_stream_arb
`default_nettype wire
